// File: rtl/fir_8tap_stream_ctrl_pkg.sv
// Shared definitions for the 8-tap streaming FIR block.
//   TAPS / SAMPLE_W / ACC_W : filter geometry and accumulator width
//   COEF                    : tap weights, tap k carries weight k+1
//   fsm_state_e             : fill / run control states
package fir_8tap_stream_ctrl_pkg;

  localparam int TAPS     = 8;
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 24;
  localparam int COEF_W   = 4;

  // Worst case 65535 * (1+2+...+8) = 2359260 fits in 24 bits unsigned.
  localparam logic [COEF_W-1:0] COEF [TAPS] = '{4'd1, 4'd2, 4'd3, 4'd4,
                                                4'd5, 4'd6, 4'd7, 4'd8};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/fir_8tap_comb.sv
// Purely combinational weighted sum of eight unsigned taps.
//   taps : packed taps, tap0 (newest sample) in bits [15:0]
//   sum  : sum over k of COEF[k] * tap k
module fir_8tap_comb
  import fir_8tap_stream_ctrl_pkg::*;
(
  input  logic [TAPS*SAMPLE_W-1:0] taps,
  output logic [ACC_W-1:0]         sum
);

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + ACC_W'(taps[k*SAMPLE_W +: SAMPLE_W]) * ACC_W'(COEF[k]);
    end
  end

endmodule

// File: rtl/fir_8tap_stream_ctrl.sv
// 8-tap streaming FIR with valid/ready handshakes, fill control and flush.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : clears delay line and fill state on this edge
//   in_valid/in_ready   : input handshake, in_data unsigned 16-bit sample
//   out_valid/out_ready : output handshake, out_data unsigned 24-bit result
//   out_count           : number of results delivered, wraps at 2^16
//   filling             : high while the delay line is still filling
module fir_8tap_stream_ctrl
  import fir_8tap_stream_ctrl_pkg::*;
#(
  parameter bit EMIT_DURING_FILL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [ACC_W-1:0]    out_data,
  input  logic                out_ready,
  output logic [15:0]         out_count,
  output logic                filling
);

  fsm_state_e state, state_nxt;
  logic [2:0] fc, fc_nxt;
  logic [SAMPLE_W-1:0] d [1:TAPS-1];
  logic [TAPS*SAMPLE_W-1:0] taps_p0;
  logic [ACC_W-1:0] acc_p0;
  logic [ACC_W-1:0] data_p1;
  logic vld_p1;
  logic [15:0] count_q;
  logic accept;
  logic load;

  // Flush blocks acceptance so a flushed cycle never mixes old and new history.
  assign in_ready = !flush && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;

  // Stage p0: current sample plus delay line through the weighted sum
  assign taps_p0 = {d[7], d[6], d[5], d[4], d[3], d[2], d[1], in_data};

  fir_8tap_comb u_comb (
    .taps (taps_p0),
    .sum  (acc_p0)
  );

  always_comb begin
    state_nxt = state;
    fc_nxt    = fc;
    load      = 1'b0;
    if (flush) begin
      state_nxt = ST_FILL;
      fc_nxt    = 3'd0;
    end else if (accept) begin
      case (state)
        ST_FILL: begin
          load = EMIT_DURING_FILL || (fc == 3'd7);
          // The eighth sample completes the history; fc then parks at 7.
          if (fc == 3'd7) state_nxt = ST_RUN;
          else            fc_nxt    = 3'(fc + 3'd1);
        end
        ST_RUN:  load = 1'b1;
        default: load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FILL;
      fc    <= 3'd0;
    end else begin
      state <= state_nxt;
      fc    <= fc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 1; k < TAPS; k++) d[k] <= '0;
    end else if (accept) begin
      d[1] <= in_data;
      for (int k = 2; k < TAPS; k++) d[k] <= d[k-1];
    end
  end

  // Stage p1: output register; a delivery and a new load may share one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= acc_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       count_q <= 16'd0;
    else if (vld_p1 && out_ready)  count_q <= count_q + 16'd1;
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_count = count_q;
  assign filling   = (state == ST_FILL);

endmodule
